// File: rtl/hms_pkg.sv
// Shared constants, state encoding and bus helpers for the merge-tree run sequencer.
package hms_pkg;

  localparam int unsigned E_LOG    = 2;
  localparam int unsigned WAYS     = 1 << E_LOG;
  localparam int unsigned DATW     = 64;
  localparam int unsigned KEYW     = 32;
  localparam int unsigned RUNW     = 32;
  localparam int unsigned TRST_CYC = 4;
  localparam int unsigned BUSW     = DATW * WAYS;
  localparam int unsigned TRSTW    = $clog2(TRST_CYC + 1);

  // All-ones record: sorts after every legal key, so it drains the tree.
  localparam logic [DATW-1:0] SENTINEL = '1;

  typedef enum logic [1:0] {
    StIdle,
    StTrst,
    StFeed,
    StFin
  } hms_state_e;

  function automatic logic [DATW-1:0] way_slice(logic [BUSW-1:0] bus, int unsigned way);
    return bus[way*DATW +: DATW];
  endfunction

endpackage

// File: rtl/hms_way_feeder.sv
// One merge-tree input: forwards len source records, then keeps the way topped up with sentinels.
module hms_way_feeder
  import hms_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            feed_en_i,
  input  logic [RUNW-1:0] len_i,
  input  logic [DATW-1:0] src_dat_i,
  input  logic            src_vld_i,
  output logic            src_rdy_o,
  input  logic            tree_full_i,
  output logic [DATW-1:0] tree_din_o,
  output logic            tree_dinen_o
);

  logic [RUNW-1:0] cnt_q, cnt_d;
  logic [DATW-1:0] din_q, din_d;
  logic            dinen_q, dinen_d;
  logic            hs;
  logic            run_done;

  assign run_done  = (cnt_q == len_i);
  assign src_rdy_o = feed_en_i & ~tree_full_i & (cnt_q < len_i);
  assign hs        = src_vld_i & src_rdy_o;

  always_comb begin
    cnt_d   = cnt_q;
    din_d   = din_q;
    dinen_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
      din_d = '0;
    end else if (hs) begin
      cnt_d   = cnt_q + RUNW'(1);
      din_d   = src_dat_i;
      dinen_d = 1'b1;
    end else if (feed_en_i && run_done) begin
      // Tree takes one beat after FULL rises, so a registered !FULL is enough throttling.
      din_d   = SENTINEL;
      dinen_d = ~tree_full_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      din_q   <= '0;
      dinen_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      dinen_q <= dinen_d;
    end
  end

  assign tree_din_o   = din_q;
  assign tree_dinen_o = dinen_q & feed_en_i;

endmodule

// File: rtl/hms_run_ctrl.sv
// Run sequencer for the 4-way merge tree: resets the tree, feeds the ways, counts merged beats.
module hms_run_ctrl
  import hms_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [RUNW-1:0] run_len_i,
  input  logic [BUSW-1:0] src_dat_i,
  input  logic [WAYS-1:0] src_vld_i,
  output logic [WAYS-1:0] src_rdy_o,
  output logic            tree_rst_o,
  output logic [BUSW-1:0] tree_din_o,
  output logic [WAYS-1:0] tree_dinen_o,
  input  logic [WAYS-1:0] tree_full_i,
  output logic            tree_in_full_o,
  input  logic [BUSW-1:0] tree_dot_i,
  input  logic            tree_doten_i,
  input  logic            out_full_i,
  output logic [BUSW-1:0] out_dot_o,
  output logic            out_doten_o,
  output logic            busy_o,
  output logic            done_o
);

  hms_state_e       state_q, state_d;
  logic [RUNW-1:0]  len_q, len_d;
  logic [RUNW-1:0]  bcnt_q, bcnt_d;
  logic [TRSTW-1:0] trst_q, trst_d;
  logic             tree_rst_q, tree_rst_d;
  logic [BUSW-1:0]  out_dot_q, out_dot_d;
  logic             out_doten_q, out_doten_d;
  logic             start_acc;
  logic             feed_en;
  logic             fwd;

  assign start_acc = (state_q == StIdle) & start_i;
  assign feed_en   = (state_q == StFeed);
  // Beats past len, or outside FEED, are sentinel beats and are dropped.
  assign fwd       = feed_en & tree_doten_i & (bcnt_q < len_q);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    bcnt_d      = bcnt_q;
    trst_d      = trst_q;
    out_doten_d = fwd;
    out_dot_d   = fwd ? tree_dot_i : out_dot_q;
    if (fwd) begin
      bcnt_d = bcnt_q + RUNW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d   = run_len_i;
          bcnt_d  = '0;
          trst_d  = '0;
          state_d = StTrst;
        end
      end
      StTrst: begin
        if (trst_q == TRSTW'(TRST_CYC - 1)) begin
          state_d = StFeed;
        end else begin
          trst_d = trst_q + TRSTW'(1);
        end
      end
      StFeed: begin
        // Also covers len == 0: leaves on the first FEED cycle.
        if (bcnt_q == len_q) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    tree_rst_d = (state_d == StTrst);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      len_q       <= '0;
      bcnt_q      <= '0;
      trst_q      <= '0;
      tree_rst_q  <= 1'b1;
      out_dot_q   <= '0;
      out_doten_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bcnt_q      <= bcnt_d;
      trst_q      <= trst_d;
      tree_rst_q  <= tree_rst_d;
      out_dot_q   <= out_dot_d;
      out_doten_q <= out_doten_d;
    end
  end

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    hms_way_feeder u_feeder (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clr_i        (start_acc),
      .feed_en_i    (feed_en),
      .len_i        (len_q),
      .src_dat_i    (way_slice(src_dat_i, i)),
      .src_vld_i    (src_vld_i[i]),
      .src_rdy_o    (src_rdy_o[i]),
      .tree_full_i  (tree_full_i[i]),
      .tree_din_o   (tree_din_o[i*DATW +: DATW]),
      .tree_dinen_o (tree_dinen_o[i])
    );
  end

  assign tree_rst_o     = tree_rst_q;
  assign tree_in_full_o = out_full_i;
  assign out_dot_o      = out_dot_q;
  assign out_doten_o    = out_doten_q;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StFin);

endmodule
